// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the scratchpad memory controller.
//   state_t : controller FSM states (idle / streaming a burst / draining the last word)
//   CL_WR   : client index of the host write port
//   CL_RD   : client index of the compute burst-read port
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int CL_WR = 0;
  localparam int CL_RD = 1;

endpackage

// File: rtl/mem_ctrl_rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_req      : request vector, indexed by CL_WR / CL_RD
//   i_advance  : a grant is being taken this cycle; move the priority pointer
//   o_grant    : one-hot grant (all zero when nothing requests)
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  // High when the compute reader holds priority; reset favours the host writer.
  logic r_favourRd;

  always_comb begin
    o_grant = 2'b00;
    if (i_req[CL_WR] && i_req[CL_RD]) begin
      if (r_favourRd) o_grant[CL_RD] = 1'b1;
      else            o_grant[CL_WR] = 1'b1;
    end else begin
      o_grant = i_req;
    end
  end

  // After any grant, priority moves to the client that did not just win.
  always_ff @(posedge clk) begin
    if (rst)
      r_favourRd <= 1'b0;
    else if (i_advance && (|o_grant))
      r_favourRd <= o_grant[CL_WR];
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
// Arbitrates the scratchpad memory's single address port between host
// single-word writes and compute burst reads; burst data is streamed out
// through a registered valid/ready interface.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   i_wr_valid/o_wr_ready          : host write handshake (i_wr_addr, i_wr_data)
//   i_rd_req_valid/o_rd_req_ready  : burst request handshake (i_rd_base, i_rd_len)
//   o_rd_data/o_rd_data_valid/i_rd_data_ready/o_rd_last : registered burst stream
//   o_busy                         : controller not idle
//   o_mem_*/i_mem_rdata            : memory port (read data is combinational)
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int D_W  = 8,
  parameter int WORD = 8,
  localparam int AW    = $clog2(WORD),
  localparam int LEN_W = $clog2(WORD) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [D_W-1:0]   i_wr_data,
  input  logic             i_rd_req_valid,
  output logic             o_rd_req_ready,
  input  logic [AW-1:0]    i_rd_base,
  input  logic [LEN_W-1:0] i_rd_len,
  output logic [D_W-1:0]   o_rd_data,
  output logic             o_rd_data_valid,
  input  logic             i_rd_data_ready,
  output logic             o_rd_last,
  output logic             o_busy,
  output logic             o_mem_rd_en,
  output logic             o_mem_wr_en,
  output logic [AW-1:0]    o_mem_addr,
  output logic [D_W-1:0]   o_mem_wdata,
  input  logic [D_W-1:0]   i_mem_rdata
);

  localparam logic [AW-1:0]    LAST_ADDR = AW'(WORD - 1);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(WORD);

  state_t            r_state;
  state_t            w_nextState;
  logic [AW-1:0]     r_curAddr;
  logic [LEN_W-1:0]  r_remaining;
  logic [D_W-1:0]    r_rdData;
  logic              r_rdValid;
  logic              r_rdLast;

  logic [1:0]        w_arbReq;
  logic [1:0]        w_grant;
  logic              w_wrInRange;
  logic              w_rdGo;
  logic              w_fetch;

  // Only arbitrate while idle; in BURST/DRAIN both clients simply wait.
  always_comb begin
    w_arbReq        = 2'b00;
    w_arbReq[CL_WR] = (r_state == ST_IDLE) && i_wr_valid;
    w_arbReq[CL_RD] = (r_state == ST_IDLE) && i_rd_req_valid;
  end

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_arbReq),
    .i_advance (r_state == ST_IDLE),
    .o_grant   (w_grant)
  );

  // Out-of-range writes are acknowledged but never reach the memory; empty or
  // out-of-range bursts are acknowledged without leaving IDLE.
  assign w_wrInRange = LEN_W'(i_wr_addr) < LEN_MAX;
  assign w_rdGo      = w_grant[CL_RD] && (i_rd_len != '0) && (LEN_W'(i_rd_base) < LEN_MAX);

  // A new word is fetched whenever the output register is empty or being drained.
  assign w_fetch = (r_state == ST_BURST) && (!r_rdValid || i_rd_data_ready);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (w_rdGo) w_nextState = ST_BURST;
      ST_BURST: if (w_fetch && (r_remaining == LEN_W'(1))) w_nextState = ST_DRAIN;
      ST_DRAIN: if (i_rd_data_ready) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Memory port: the fetch path and the write grant are mutually exclusive by
  // state, so rd_en and wr_en can never be high together.
  always_comb begin
    o_wr_ready     = w_grant[CL_WR];
    o_rd_req_ready = w_grant[CL_RD];
    o_busy         = (r_state != ST_IDLE);
    o_mem_rd_en    = w_fetch;
    o_mem_wr_en    = w_grant[CL_WR] && w_wrInRange;
    o_mem_addr     = '0;
    o_mem_wdata    = '0;
    if (w_fetch) begin
      o_mem_addr = r_curAddr;
    end else if (w_grant[CL_WR]) begin
      o_mem_addr  = i_wr_addr;
      o_mem_wdata = i_wr_data;
    end
  end

  // Burst bookkeeping and the registered output stage. Lengths beyond the
  // memory depth are clamped so a burst never revisits a word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_curAddr   <= '0;
      r_remaining <= '0;
      r_rdData    <= '0;
      r_rdValid   <= 1'b0;
      r_rdLast    <= 1'b0;
    end else begin
      if (w_rdGo) begin
        r_curAddr   <= i_rd_base;
        r_remaining <= (i_rd_len > LEN_MAX) ? LEN_MAX : i_rd_len;
      end
      if (w_fetch) begin
        r_rdData    <= i_mem_rdata;
        r_rdValid   <= 1'b1;
        r_rdLast    <= (r_remaining == LEN_W'(1));
        r_remaining <= r_remaining - LEN_W'(1);
        r_curAddr   <= (r_curAddr == LAST_ADDR) ? '0 : r_curAddr + AW'(1);
      end
      if ((r_state == ST_DRAIN) && i_rd_data_ready) begin
        r_rdValid <= 1'b0;
        r_rdLast  <= 1'b0;
      end
    end
  end

  assign o_rd_data       = r_rdData;
  assign o_rd_data_valid = r_rdValid;
  assign o_rd_last       = r_rdLast;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Controller and arbiter for the scratchpad register-file memory in the TPU datapath.
- Shares the memory's single address port between two clients: a host loader issuing single-word writes, and the compute engine issuing burst reads (base, length).
- Burst read data is streamed out through a registered valid/ready interface.
- Sits between the host/compute front-ends and the memory instance; drives the memory's rd_en/wr_en/addr/data_in and consumes its combinational data_out.

Parameters:
D_W, 8, data word width
WORD, 8, memory depth in words
AW, $clog2(WORD), address width (localparam, derived)
LEN_W, $clog2(WORD)+1, burst length field width (localparam, derived)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
wr_valid  in  1  host write request
wr_ready  out  1  host write accepted this cycle
wr_addr  in  AW  host write address
wr_data  in  D_W  host write data
rd_req_valid  in  1  compute burst request
rd_req_ready  out  1  burst request accepted this cycle
rd_base  in  AW  burst start address
rd_len  in  LEN_W  burst length in words
rd_data  out  D_W  burst data (registered)
rd_data_valid  out  1  rd_data holds a word
rd_data_ready  in  1  consumer accepts word
rd_last  out  1  current word is the final word of the burst
busy  out  1  state != IDLE
mem_rd_en  out  1  memory read enable
mem_wr_en  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  D_W  memory write data
mem_rdata  in  D_W  memory read data (combinational from mem_addr)

Behaviour:
- Reset: state IDLE, rd_data=0, rd_data_valid=0, rd_last=0, rr_ptr favours write. Combinational outputs are 0 with no grant.
- States: IDLE, BURST, DRAIN.
- IDLE arbitration:
  - Round-robin between wr_valid and rd_req_valid.
  - rr_ptr flips to the other client after every grant.
  - A lone requester always wins.
- Write grant, same cycle:
  - wr_ready=1, mem_wr_en=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - Data lands at the clock edge. Stay in IDLE, so back-to-back writes run at 1/cycle absent reads.
- Write with wr_addr >= WORD: wr_ready=1, mem_wr_en=0 (dropped).
- Read grant:
  - rd_req_ready=1; latch cur_addr=rd_base and remaining=min(rd_len, WORD); go to BURST.
  - If rd_len=0 or rd_base>=WORD: accepted, no data, stay in IDLE (still counts as a grant for round-robin).
- BURST:
  - Fetch when (!rd_data_valid || rd_data_ready): mem_rd_en=1, mem_addr=cur_addr.
  - On fetch, at the edge: rd_data<=mem_rdata, rd_data_valid<=1, rd_last<=(remaining==1), remaining--.
  - cur_addr increments and wraps from WORD-1 to 0.
  - After the fetch of the last word, go to DRAIN.
  - Consumer stall (valid && !ready): no fetch; rd_data and rd_last are held stable.
- DRAIN: when rd_data_ready, at the edge rd_data_valid<=0, rd_last<=0, go to IDLE.
- Writes are blocked (wr_ready=0) in BURST and DRAIN. A new request is not arbitrated until IDLE.
- Latency, with the request accepted in cycle t and rd_data_ready held high:
  - First valid word in cycle t+2.
  - One word per cycle thereafter.
  - Last word in cycle t+1+len.
  - Back in IDLE at t+2+len.
- mem_rd_en and mem_wr_en are never both high.
- Reset mid-burst: burst aborts; valid and last clear on the reset edge; no further memory accesses.

Decomposition:
- Shared package: state enum (IDLE/BURST/DRAIN) and the client index constants (CL_WR=0, CL_RD=1).
- One sub-module: rr_arb2, a 2-requester round-robin arbiter. Inputs: req[1:0], advance. Outputs: one-hot grant[1:0]. Holds its own pointer register, reset to favour CL_WR.

Test Plan:
- Write 0xA0+i to addresses 0..7 with back-to-back wr_valid → wr_ready is high every cycle, 8 mem_wr_en pulses, then memory[i]=0xA0+i.
- Burst base=2 len=4, ready high → rd_data 0xA2,0xA3,0xA4,0xA5 in cycles t+2..t+5; rd_last only on 0xA5; busy low at t+6.
- Burst base=6 len=4 → words 0xA6,0xA7,0xA0,0xA1 (address wrap); len=9 is clamped to 8 words.
- wr_valid and rd_req_valid high together from reset → write granted first; read granted on the next IDLE arbitration; while both are held, grants alternate.
- Burst len=3 with rd_data_ready toggled 1,0,0,1,… → no word lost or duplicated; rd_data stable while stalled; mem_rd_en only on fetch cycles.
- rd_len=0 request; then reset asserted in the second cycle of an 8-word burst → no data for len=0; after reset, rd_data_valid=0, state IDLE, no mem_rd_en.
